// File: rtl/kl8_pkg.sv
`default_nettype none
//============================================================================
// Module      : kl8_pkg
// Description : Shared types and constants for the multi-channel KL8 console
//               controller: TX/RX state encodings, IOP bit positions, the
//               device-code field of MB and the idle (no data) bus value.
// Revision    : 1.0  initial release
//============================================================================
package kl8_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Bit positions of the IOP pulses in the packed {iop_4, iop_2, iop_1} vector
    localparam int c_iop1_bit = 0;
    localparam int c_iop2_bit = 1;
    localparam int c_iop4_bit = 2;

    // Device code field of MB during an IOT
    localparam int c_dev_msb = 8;
    localparam int c_dev_lsb = 3;

    // Low-true data bus value meaning "nothing driven"
    localparam logic [11:0] c_idle_data = 12'o7777;

    // Channel k owns an adjacent pair of codes: keyboard base+2k, printer base+2k+1
    function automatic logic [5:0] dev_code(input logic [5:0] base,
                                            input int unsigned chan,
                                            input logic is_tty);
        return base + 6'(2 * chan) + {5'b0, is_tty};
    endfunction

endpackage
`default_nettype wire

// File: rtl/kl8_chan.sv
`default_nettype none
//============================================================================
// Module      : kl8_chan
// Description : One KL8 serial channel: 8N1 receiver feeding a keyboard FIFO,
//               8N1 transmitter with teleprinter flag, and this channel's
//               contribution to the skip / clear-AC / data / interrupt terms.
// Ports       : clk, rst          clock, async active-high reset
//               pwr_clr           synchronous clear of all channel state
//               rx_data, tx_data  serial line in (async) / out (idle high)
//               sel_kbd, sel_tty  this channel's device codes are on MB
//               iop_1/2/4         IOT pulse levels
//               iop_2/4_rise      single-cycle rising-edge strobes
//               tx_char           character from AC for TLS/TPC
//               skp, clr_ac, data high-true bus terms (OR-ed by the top)
//               flag              kbd flag | tty flag, for the interrupt
//               rx_ovr            sticky FIFO overrun
// Revision    : 1.0  initial release
//============================================================================
module kl8_chan
    import kl8_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int RX_DEPTH     = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_clr,
    input  logic        rx_data,
    output logic        tx_data,
    input  logic        sel_kbd,
    input  logic        sel_tty,
    input  logic        iop_1,
    input  logic        iop_2,
    input  logic        iop_4,
    input  logic        iop_2_rise,
    input  logic        iop_4_rise,
    input  logic [7:0]  tx_char,
    output logic        skp,
    output logic        clr_ac,
    output logic [11:0] data,
    output logic        flag,
    output logic        rx_ovr
);

    localparam int              c_cw        = $clog2(CLKS_PER_BIT);
    localparam int              c_aw        = $clog2(RX_DEPTH);
    localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);

    //------------------------------------------------------------------
    // Transmitter
    //------------------------------------------------------------------
    tx_state_t       r_tx_state;
    logic [c_cw-1:0] r_tx_cnt;
    logic [2:0]      r_tx_idx;
    logic [7:0]      r_tx_shift;
    logic            r_tx_data;
    logic            r_tty_flag;
    logic            w_tx_tick;
    logic            w_tx_load;

    assign w_tx_tick = (r_tx_cnt == c_bit_last);
    // A TPC that arrives while a frame is in flight is simply dropped
    assign w_tx_load = iop_4_rise & sel_tty & (r_tx_state == TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_data  <= 1'b1;
            r_tty_flag <= 1'b0;
        end else if (pwr_clr) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_data  <= 1'b1;
            r_tty_flag <= 1'b0;
        end else begin
            if (iop_2_rise && sel_tty) begin
                r_tty_flag <= 1'b0;
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_state <= TX_START;
                        r_tx_cnt   <= '0;
                        r_tx_shift <= tx_char;
                        r_tx_data  <= 1'b0;
                        r_tty_flag <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= TX_DATA;
                        r_tx_cnt   <= '0;
                        r_tx_idx   <= '0;
                        r_tx_data  <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_tx_data  <= 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 1'b1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_data  <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_cnt   <= '0;
                        // Completion wins over a coincident TCF so it is never lost
                        r_tty_flag <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx_data  <= 1'b1;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Receiver (2-FF synchroniser, centre sampling)
    //------------------------------------------------------------------
    logic            r_rx_s1;
    logic            r_rx_s2;
    rx_state_t       r_rx_state;
    logic [c_cw-1:0] r_rx_cnt;
    logic [2:0]      r_rx_idx;
    logic [7:0]      r_rx_shift;
    logic            w_rx_tick;
    logic            w_push;

    assign w_rx_tick = (r_rx_cnt == c_bit_last);
    // Good stop bit: byte offered to the FIFO on the stop-sample edge
    assign w_push    = (r_rx_state == RX_STOP) & w_rx_tick & r_rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else if (pwr_clr) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1 <= rx_data;
            r_rx_s2 <= r_rx_s1;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == c_half_last) begin
                        // Line back high at mid-start means a glitch, not a frame
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_state <= RX_IDLE;
                        r_rx_cnt   <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Keyboard FIFO
    //------------------------------------------------------------------
    logic [7:0]    r_mem [RX_DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          r_ovr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [7:0]    w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop   = iop_2_rise & sel_kbd & ~w_empty;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovr    <= 1'b0;
        end else if (pwr_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------
    // Bus terms (levels, only while the relevant pulse is high)
    //------------------------------------------------------------------
    assign skp     = iop_1 & ((sel_kbd & ~w_empty) | (sel_tty & r_tty_flag));
    assign clr_ac  = iop_2 & sel_kbd;
    assign data    = (iop_4 & sel_kbd) ? {4'b0, w_head} : 12'd0;
    assign flag    = ~w_empty | r_tty_flag;
    assign tx_data = r_tx_data;
    assign rx_ovr  = r_ovr;

endmodule
`default_nettype wire

// File: rtl/kl8_multi.sv
`default_nettype none
//============================================================================
// Module      : kl8_multi
// Description : N-channel KL8 console controller on the PDP-8/I positive I/O
//               bus. Detects IOP rising edges, decodes the device codes of
//               each channel and combines the per-channel bus terms into the
//               low-true wired skip, clear-AC, data and interrupt lines.
// Ports       : clk, rst             clock, async active-high reset
//               rx_data / tx_data    NCHAN serial lines, idle high
//               iop_1/2/4            IOT pulses, high-true
//               io_bmb, io_bac       MB (device code) and AC (character)
//               i_o_pwr_clr          I/O power clear, synchronous
//               i_o_skp_rq_l         skip request, low-true
//               i_o_int_rq_l         interrupt request, low-true
//               i_o_0_to_ac_l        clear AC, low-true
//               io_data_l            data into AC, low-true
//               rx_ovr               sticky overrun per channel
// Revision    : 1.0  initial release
//============================================================================
module kl8_multi
    import kl8_pkg::*;
#(
    parameter int         NCHAN        = 1,
    parameter logic [5:0] DEV_BASE     = 6'o03,
    parameter int         CLKS_PER_BIT = 434,
    parameter int         RX_DEPTH     = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] rx_data,
    output logic [NCHAN-1:0] tx_data,
    input  logic             iop_1,
    input  logic             iop_2,
    input  logic             iop_4,
    input  logic [11:0]      io_bmb,
    input  logic [11:0]      io_bac,
    input  logic             i_o_pwr_clr,
    output logic             i_o_skp_rq_l,
    output logic             i_o_int_rq_l,
    output logic             i_o_0_to_ac_l,
    output logic [11:0]      io_data_l,
    output logic [NCHAN-1:0] rx_ovr
);

    // IOP pulses last several clocks; act once, on the first clock they are seen high
    logic [2:0] w_iop;
    logic [2:0] r_iop_d;
    logic [2:0] w_rise;

    assign w_iop  = {iop_4, iop_2, iop_1};
    assign w_rise = w_iop & ~r_iop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iop_d <= '0;
        end else begin
            r_iop_d <= w_iop;
        end
    end

    logic [NCHAN-1:0]       w_skp;
    logic [NCHAN-1:0]       w_clr;
    logic [NCHAN-1:0]       w_flag;
    logic [NCHAN-1:0][11:0] w_data;
    logic [5:0]             w_dev;

    assign w_dev = io_bmb[c_dev_msb:c_dev_lsb];

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        localparam logic [5:0] c_kbd_code = dev_code(DEV_BASE, k, 1'b0);
        localparam logic [5:0] c_tty_code = dev_code(DEV_BASE, k, 1'b1);

        logic w_sel_kbd;
        logic w_sel_tty;

        assign w_sel_kbd = (w_dev == c_kbd_code);
        assign w_sel_tty = (w_dev == c_tty_code);

        kl8_chan #(
            .CLKS_PER_BIT (CLKS_PER_BIT),
            .RX_DEPTH     (RX_DEPTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .pwr_clr    (i_o_pwr_clr),
            .rx_data    (rx_data[k]),
            .tx_data    (tx_data[k]),
            .sel_kbd    (w_sel_kbd),
            .sel_tty    (w_sel_tty),
            .iop_1      (iop_1),
            .iop_2      (iop_2),
            .iop_4      (iop_4),
            .iop_2_rise (w_rise[c_iop2_bit]),
            .iop_4_rise (w_rise[c_iop4_bit]),
            .tx_char    (io_bac[7:0]),
            .skp        (w_skp[k]),
            .clr_ac     (w_clr[k]),
            .data       (w_data[k]),
            .flag       (w_flag[k]),
            .rx_ovr     (rx_ovr[k])
        );
    end

    logic [11:0] w_data_or;

    always_comb begin
        w_data_or = 12'd0;
        for (int k = 0; k < NCHAN; k++) begin
            w_data_or = w_data_or | w_data[k];
        end
    end

    assign i_o_skp_rq_l  = ~|w_skp;
    assign i_o_0_to_ac_l = ~|w_clr;
    assign i_o_int_rq_l  = ~|w_flag;
    assign io_data_l     = c_idle_data & ~w_data_or;

    // MB/AC bits outside the device field and the character are not decoded here
    logic w_unused;
    assign w_unused = ^{io_bac[11:8], io_bmb[11:9], io_bmb[2:0], w_rise[c_iop1_bit]};

endmodule
`default_nettype wire

// File: tb/tb_kl8_multi.sv
`default_nettype none
//============================================================================
// Module      : tb_kl8_multi
// Description : Directed self-checking bench for kl8_multi with two channels,
//               16 clocks per bit and a 4-deep keyboard FIFO.
// Revision    : 1.0  initial release
//============================================================================
module tb_kl8_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx_data = 2'b11;
    logic [1:0]  tx_data;
    logic        iop_1 = 1'b0;
    logic        iop_2 = 1'b0;
    logic        iop_4 = 1'b0;
    logic [11:0] io_bmb = 12'd0;
    logic [11:0] io_bac = 12'd0;
    logic        pwr_clr = 1'b0;
    logic        skp_l;
    logic        int_l;
    logic        clr_l;
    logic [11:0] data_l;
    logic [1:0]  rx_ovr;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [9:0] exp_frame;
    logic [7:0] ovr_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] full_bytes [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    always #5 clk = ~clk;

    kl8_multi #(
        .NCHAN        (2),
        .DEV_BASE     (6'o03),
        .CLKS_PER_BIT (16),
        .RX_DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .tx_data       (tx_data),
        .iop_1         (iop_1),
        .iop_2         (iop_2),
        .iop_4         (iop_4),
        .io_bmb        (io_bmb),
        .io_bac        (io_bac),
        .i_o_pwr_clr   (pwr_clr),
        .i_o_skp_rq_l  (skp_l),
        .i_o_int_rq_l  (int_l),
        .i_o_0_to_ac_l (clr_l),
        .io_data_l     (data_l),
        .rx_ovr        (rx_ovr)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %o expected %o", tag, obs, exp);
        end
    endtask

    // Raise the pulse selected by instr[2:0]; returns on the negedge after the acting posedge
    task automatic iot(input logic [11:0] instr, input logic [11:0] ac);
        io_bmb = instr;
        io_bac = ac;
        case (instr[2:0])
            3'd1:    iop_1 = 1'b1;
            3'd2:    iop_2 = 1'b1;
            3'd4:    iop_4 = 1'b1;
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic iot_end();
        iop_1 = 1'b0;
        iop_2 = 1'b0;
        iop_4 = 1'b0;
        @(negedge clk);
    endtask

    // 8N1 frame, 16 clocks per bit; a bad stop bit is held low just past its centre
    task automatic send_byte(input int ch, input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9 && !stop_ok) begin
                rx_data[ch] = 1'b0;
                repeat (10) @(negedge clk);
                rx_data[ch] = 1'b1;
                repeat (20) @(negedge clk);
            end else begin
                rx_data[ch] = frame[i];
                repeat (15) @(negedge clk);
            end
        end
    endtask

    // KRS then KCC on channel ch
    task automatic read_kbd(input int ch, input logic [7:0] exp, input string tag);
        logic [11:0] base;
        base = 12'o6030 + 12'(ch * 16);
        iot(base | 12'o4, 12'd0);
        chk({tag, "_krs"}, data_l, ~{4'b0, exp});
        iot_end();
        iot(base | 12'o2, 12'd0);
        chk({tag, "_kcc"}, 12'(clr_l), 12'd0);
        iot_end();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_idle", 12'(tx_data), 12'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_skp", 12'(skp_l), 12'd1);
        chk("rst_int", 12'(int_l), 12'd1);
        chk("rst_clr", 12'(clr_l), 12'd1);
        chk("rst_data", data_l, 12'o7777);
        chk("rst_ovr", 12'(rx_ovr), 12'd0);

        // Receive 0x41 on channel 0
        send_byte(0, 8'h41, 1'b1);
        chk("rx41_int", 12'(int_l), 12'd0);
        iot(12'o6031, 12'd0);
        chk("rx41_ksf", 12'(skp_l), 12'd0);
        iot_end();
        iot(12'o6051, 12'd0);
        chk("rx41_ksf_other_chan", 12'(skp_l), 12'd1);
        iot_end();
        iot(12'o6034, 12'd0);
        chk("rx41_krs", data_l, 12'o7676);
        iot_end();
        iot(12'o6031, 12'd0);
        chk("rx41_ksf_after_krs", 12'(skp_l), 12'd0);
        iot_end();
        iot(12'o6032, 12'd0);
        chk("rx41_kcc", 12'(clr_l), 12'd0);
        iot_end();
        iot(12'o6031, 12'd0);
        chk("rx41_ksf_empty", 12'(skp_l), 12'd1);
        iot_end();
        chk("rx41_int_clear", 12'(int_l), 12'd1);

        // TLS AC=0123 on channel 1 (printer code 06)
        iot(12'o6062, 12'd0);
        iot_end();
        iot(12'o6064, 12'o0123);
        iop_4 = 1'b0;
        exp_frame = 10'b1_0101_0011_0;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 8 : 16) @(negedge clk);
            chk($sformatf("tx_bit%0d", i), 12'(tx_data[1]), 12'(exp_frame[i]));
        end
        io_bmb = 12'o6061;
        iop_1  = 1'b1;
        #1;
        chk("tsf_busy", 12'(skp_l), 12'd1);
        repeat (7) @(negedge clk);
        chk("tsf_159", 12'(skp_l), 12'd1);
        @(negedge clk);
        chk("tsf_160", 12'(skp_l), 12'd0);
        chk("tx_done_int", 12'(int_l), 12'd0);
        iop_1 = 1'b0;
        @(negedge clk);
        iot(12'o6062, 12'd0);
        iot_end();
        chk("tcf_int", 12'(int_l), 12'd1);
        chk("tx_idle_after", 12'(tx_data[1]), 12'd1);

        // Overrun: five bytes, no reads
        for (int i = 0; i < 5; i++) begin
            send_byte(0, ovr_bytes[i], 1'b1);
        end
        chk("ovr_flag", 12'(rx_ovr), 12'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovr_int_before_pop%0d", i), 12'(int_l), 12'd0);
            read_kbd(0, ovr_bytes[i], $sformatf("ovr%0d", i));
        end
        chk("ovr_int_drained", 12'(int_l), 12'd1);
        iot(12'o6031, 12'd0);
        chk("ovr_ksf_empty", 12'(skp_l), 12'd1);
        iot_end();
        chk("ovr_sticky", 12'(rx_ovr), 12'd1);

        // Framing error on channel 1
        send_byte(1, 8'h7E, 1'b0);
        repeat (20) @(negedge clk);
        iot(12'o6051, 12'd0);
        chk("frame_err_ksf", 12'(skp_l), 12'd1);
        iot_end();
        chk("frame_err_int", 12'(int_l), 12'd1);

        // Short low glitch on idle line
        rx_data[1] = 1'b0;
        repeat (4) @(negedge clk);
        rx_data[1] = 1'b1;
        repeat (40) @(negedge clk);
        iot(12'o6051, 12'd0);
        chk("glitch_ksf", 12'(skp_l), 12'd1);
        iot_end();

        // Full FIFO: KCC pop lands on the same edge as the fifth stop-bit sample
        for (int i = 0; i < 4; i++) begin
            send_byte(1, full_bytes[i], 1'b1);
        end
        io_bmb = 12'o6052;
        fork
            send_byte(1, full_bytes[4], 1'b1);
            begin
                repeat (155) @(negedge clk);
                iop_2 = 1'b1;
                @(negedge clk);
                iop_2 = 1'b0;
            end
        join
        chk("coinc_ovr", 12'(rx_ovr[1]), 12'd0);
        for (int i = 1; i < 5; i++) begin
            read_kbd(1, full_bytes[i], $sformatf("coinc%0d", i));
        end
        iot(12'o6051, 12'd0);
        chk("coinc_ksf_empty", 12'(skp_l), 12'd1);
        iot_end();

        // Busy TPC ignored, then power clear mid-frame
        send_byte(1, 8'h5A, 1'b1);
        chk("pc_int_before", 12'(int_l), 12'd0);
        iot(12'o6044, 12'o0017);
        iop_4 = 1'b0;
        repeat (20) @(negedge clk);
        io_bac = 12'o0360;
        iop_4  = 1'b1;
        @(negedge clk);
        iop_4 = 1'b0;
        repeat (35) @(negedge clk);
        chk("busy_tpc_bit2", 12'(tx_data[0]), 12'd1);
        repeat (32) @(negedge clk);
        chk("busy_tpc_bit4", 12'(tx_data[0]), 12'd0);
        pwr_clr = 1'b1;
        @(negedge clk);
        chk("pc_tx_idle", 12'(tx_data), 12'd3);
        chk("pc_int", 12'(int_l), 12'd1);
        chk("pc_ovr", 12'(rx_ovr), 12'd0);
        pwr_clr = 1'b0;
        @(negedge clk);
        iot(12'o6051, 12'd0);
        chk("pc_ksf", 12'(skp_l), 12'd1);
        iot_end();
        repeat (200) @(negedge clk);
        chk("pc_no_late_flag", 12'(int_l), 12'd1);

        // Asynchronous reset mid-frame
        iot(12'o6064, 12'd0);
        iop_4 = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_low", 12'(tx_data[1]), 12'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_tx_idle", 12'(tx_data), 12'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_int", 12'(int_l), 12'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
